// File: rtl/aes_inv_round_front.sv
// Front half of an AES decryption round: InvShiftRows -> InvSubBytes -> AddRoundKey.
// Inverse S-boxes are applied SBOX_PER_CYCLE bytes per cycle in place on the work register.
module aes_inv_round_front #(
    parameter int unsigned SBOX_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [127:0] in_key,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         out_last,
    output logic         busy
);

    localparam int unsigned N       = SBOX_PER_CYCLE;
    localparam int unsigned STEPS   = 16 / N;
    localparam int unsigned STEP_W  = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned CHUNK_W = 8 * N;

    if (N != 1 && N != 2 && N != 4 && N != 8 && N != 16) begin : g_bad_sbox_per_cycle
        $error("aes_inv_round_front: SBOX_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse affine transform followed by x^254 (multiplicative inverse, 0 maps to 0).
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] a;
        logic [7:0] p;
        logic [7:0] r;
        a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    state_e              state_q, state_d;
    logic [127:0]        work_q, work_d;
    logic [127:0]        key_q, key_d;
    logic                last_q, last_d;
    logic [STEP_W-1:0]   step_q, step_d;

    logic [127:0]        shifted;
    logic [31:0]         base;
    logic [CHUNK_W-1:0]  chunk_in;
    logic [CHUNK_W-1:0]  chunk_key;
    logic [CHUNK_W-1:0]  chunk_out;

    // InvShiftRows: row r of column c comes from column (c - r) mod 4.
    always_comb begin
        shifted = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[8*(4*c+r) +: 8] = in_state[8*(4*((c-r+4)%4)+r) +: 8];
            end
        end
    end

    always_comb begin
        base      = 32'(step_q) * CHUNK_W;
        chunk_in  = work_q[base +: CHUNK_W];
        chunk_key = key_q[base +: CHUNK_W];
        chunk_out = '0;
        for (int i = 0; i < int'(N); i++) begin
            chunk_out[8*i +: 8] = inv_sbox(chunk_in[8*i +: 8]) ^ chunk_key[8*i +: 8];
        end
    end

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        key_d     = key_q;
        last_d    = last_q;
        step_d    = step_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    work_d  = shifted;
                    key_d   = in_key;
                    last_d  = in_last;
                    step_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                busy                    = 1'b1;
                work_d[base +: CHUNK_W] = chunk_out;
                if (step_q == STEP_W'(STEPS - 1)) begin
                    step_d  = '0;
                    state_d = DONE;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        work_d  = shifted;
                        key_d   = in_key;
                        last_d  = in_last;
                        step_d  = '0;
                        state_d = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                step_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            key_q   <= '0;
            last_q  <= 1'b0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            key_q   <= key_d;
            last_q  <= last_d;
            step_q  <= step_d;
        end
    end

    assign out_state = work_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_aes_inv_round_front.sv
// Scoreboard bench for aes_inv_round_front: directed blocks on an N=4 instance plus
// a latency/result sweep over every legal SBOX_PER_CYCLE.
module tb_aes_inv_round_front;

    localparam int unsigned NI   = 5;
    localparam int unsigned MAIN = 2;

    typedef struct packed {
        logic         last;
        logic [127:0] st;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_state;
    logic [127:0] in_key;
    logic         in_last;
    logic         out_ready;

    logic         ir [NI];
    logic         ov [NI];
    logic         bs [NI];
    logic         ol [NI];
    logic [127:0] os [NI];

    int checks = 0;
    int errors = 0;

    exp_t       sb [$];
    exp_t       sb_e;
    logic [7:0] inv_tab [256];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        aes_inv_round_front #(.SBOX_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (ir[g]),
            .in_state  (in_state),
            .in_key    (in_key),
            .in_last   (in_last),
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .out_state (os[g]),
            .out_last  (ol[g]),
            .busy      (bs[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [128:0] obs, input logic [128:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = (x[7]) ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // Forward S-box by brute-force inverse, then inverted into a lookup table.
    task automatic build_table();
        logic [7:0] z;
        logic [7:0] s;
        for (int y = 0; y < 256; y++) begin
            z = 8'h00;
            for (int k = 1; k < 256; k++) begin
                if (m_mul(8'(y), 8'(k)) == 8'h01) z = 8'(k);
            end
            s = z ^ rotl8(z, 1) ^ rotl8(z, 2) ^ rotl8(z, 3) ^ rotl8(z, 4) ^ 8'h63;
            inv_tab[s] = 8'(y);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] st, input logic [127:0] key);
        logic [127:0] res;
        logic [7:0]   b;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                b = st[8*(4*((c-r+4)%4)+r) +: 8];
                res[8*(4*c+r) +: 8] = inv_tab[b] ^ key[8*(4*c+r) +: 8];
            end
        end
        return res;
    endfunction

    // FIPS-197 text lists byte 0 first; the port packs byte 0 in the low bits.
    function automatic logic [127:0] repack(input logic [127:0] x);
        logic [127:0] res;
        for (int k = 0; k < 16; k++) res[8*k +: 8] = x[8*(15-k) +: 8];
        return res;
    endfunction

    // Scoreboard: push on accept, pop on output handshake of the N=4 instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (ov[MAIN] && out_ready) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_underflow observed=%h expected=none", {ol[MAIN], os[MAIN]});
                end
                if (sb.size() != 0) begin
                    sb_e = sb.pop_front();
                    chk("sb_result", {ol[MAIN], os[MAIN]}, sb_e);
                end
            end
            if (in_valid && ir[MAIN]) sb.push_back({in_last, model(in_state, in_key)});
        end
    end

    task automatic drive(input logic [127:0] st, input logic [127:0] key, input logic last,
                         input logic rdy, output int waits);
        @(posedge clk);
        #1;
        in_state  = st;
        in_key    = key;
        in_last   = last;
        in_valid  = 1'b1;
        out_ready = rdy;
        waits     = 0;
        @(negedge clk);
        while (!ir[MAIN] && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        chk("accept_ready", 129'(ir[MAIN]), 129'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int idx, output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (ov[idx]) break;
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    localparam logic [127:0] IS_START = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [127:0] IS_BOX   = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
    localparam logic [127:0] SWEEP_K  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

    initial begin
        int           lat;
        int           waits;
        logic [127:0] st;
        logic [127:0] key;
        logic [127:0] hold;
        int           lat_a [NI];
        logic [127:0] res_a [NI];

        build_table();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        in_key    = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        #12;
        chk("rst_in_ready", 129'(ir[MAIN]), 129'(1));
        chk("rst_out_valid", 129'(ov[MAIN]), 129'(0));
        chk("rst_busy", 129'(bs[MAIN]), 129'(0));
        chk("rst_out", {ol[MAIN], os[MAIN]}, 129'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Zero block: every byte becomes InvSBox(0) = 0x52.
        drive('0, '0, 1'b0, 1'b1, waits);
        wait_out(MAIN, lat);
        chk("t1_latency", 129'(lat), 129'(4));
        chk("t1_state", {ol[MAIN], os[MAIN]}, {1'b0, {16{8'h52}}});

        // 0x63 everywhere, all-ones key, final round flag.
        drive({16{8'h63}}, {16{8'hff}}, 1'b1, 1'b1, waits);
        wait_out(MAIN, lat);
        chk("t2_latency", 129'(lat), 129'(4));
        chk("t2_state", {ol[MAIN], os[MAIN]}, {1'b1, {16{8'hff}}});

        // Row 1, column 0 moves to column 1 (byte 5).
        st         = {16{8'h63}};
        st[15:8]   = 8'h7c;
        key        = '0;
        key[47:40] = 8'h01;
        drive(st, '0, 1'b0, 1'b1, waits);
        wait_out(MAIN, lat);
        chk("t3_latency", 129'(lat), 129'(4));
        chk("t3_state", 129'(os[MAIN]), 129'(key));

        // Backpressure: result must hold while out_ready is low.
        drive(128'h00112233445566778899aabbccddeeff, 128'h0123456789abcdeffedcba9876543210,
              1'b0, 1'b0, waits);
        wait_out(MAIN, lat);
        chk("t4_latency", 129'(lat), 129'(4));
        hold = os[MAIN];
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("t4_hold_valid", 129'(ov[MAIN]), 129'(1));
            chk("t4_hold_state", 129'(os[MAIN]), 129'(hold));
            chk("t4_hold_in_ready", 129'(ir[MAIN]), 129'(0));
        end
        drive(128'hdeadbeefcafef00d0badc0de12345678, 128'h55aa55aa55aa55aa33cc33cc33cc33cc,
              1'b1, 1'b1, waits);
        chk("t4_same_edge", 129'(waits), 129'(0));
        wait_out(MAIN, lat);
        chk("t4_next_latency", 129'(lat), 129'(4));

        // Async reset at step 2 of a block.
        drive(128'hffeeddccbbaa99887766554433221100, 128'h1111111122222222333333334444444,
              1'b1, 1'b1, waits);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("t5_busy_before", 129'(bs[MAIN]), 129'(1));
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", 129'(ov[MAIN]), 129'(0));
        chk("t5_rst_ready", 129'(ir[MAIN]), 129'(1));
        chk("t5_rst_busy", 129'(bs[MAIN]), 129'(0));
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        st  = 128'h0f0e0d0c0b0a09080706050403020100;
        key = 128'h9999888877776666555544443333aaaa;
        drive(st, key, 1'b0, 1'b1, waits);
        wait_out(MAIN, lat);
        chk("t5_latency", 129'(lat), 129'(4));
        chk("t5_state", {ol[MAIN], os[MAIN]}, {1'b0, model(st, key)});

        // Sweep every width against the FIPS-197 Appendix C round-1 vectors.
        for (int pass = 0; pass < 2; pass++) begin
            pulse_reset();
            key = (pass == 0) ? '0 : SWEEP_K;
            for (int g = 0; g < NI; g++) begin
                lat_a[g] = 0;
                res_a[g] = '0;
            end
            drive(repack(IS_START), key, 1'(pass), 1'b1, waits);
            for (int cnt = 1; cnt <= 24; cnt++) begin
                @(posedge clk);
                @(negedge clk);
                for (int g = 0; g < NI; g++) begin
                    if (ov[g] && lat_a[g] == 0) begin
                        lat_a[g] = cnt;
                        res_a[g] = os[g];
                    end
                end
            end
            for (int g = 0; g < NI; g++) begin
                chk($sformatf("t6_latency_n%0d", 1 << g), 129'(lat_a[g]), 129'(16 >> g));
                chk($sformatf("t6_state_n%0d", 1 << g), 129'(res_a[g]), 129'(repack(IS_BOX) ^ key));
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", 129'(sb.size()), 129'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
